filter_round_sched: RTL and testbench

Sequencer for the filter issue unit. It runs a programmed number of filter rounds back to back. For each round it resets and releases the issue unit, waits for the unit's done flag, then waits for the allocators to drain before starting the next round. It sits between host configuration registers and the issue unit, supplying each round's filter length and memory base address.

---
 rtl/filter_round_sched.sv | 201 ++++++++++++++++++++
 tb/tb_filter_round_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_round_sched.sv
// filter_round_sched: runs a programmed number of filter rounds back to back.
// Each round arms (resets) the issue unit, releases it, waits for issue_done,
// then waits for the allocators to stay idle for DRAIN_CYCLES+1 cycles before
// the next round.  Per-round base address advances by the latched filter length.
//
// Optional feature macro: ROUND_TIMEOUT_EN
//   defined   -> 16-bit watchdog over ISSUE+DRAIN; on expiry jump to DONE, timeout=1
//   undefined -> no watchdog, timeout tied 0
module filter_round_sched #(
    parameter int unsigned ROUND_W        = 8,
    parameter int unsigned LEN_W          = 13,
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DRAIN_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_start,
    input  logic [ROUND_W-1:0] cfg_num_rounds,
    input  logic [LEN_W-1:0]   cfg_filter_length,
    input  logic [ADDR_W-1:0]  cfg_base_addr,
    output logic               issue_rst,
    output logic [LEN_W-1:0]   issue_length,
    output logic [ADDR_W-1:0]  issue_base_addr,
    input  logic               issue_done,
    input  logic               alloc_busy,
    output logic [ROUND_W-1:0] round_idx,
    output logic               round_start,
    output logic               busy,
    output logic               all_done,
    output logic               timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_ISSUE,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    // Parameter sanity: the drain counter is 4 bits, the watchdog 16 bits.
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
        $error("DRAIN_CYCLES must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t             state;
    logic [ROUND_W-1:0] num_rounds;
    logic [3:0]         drain_cnt;
    logic [ADDR_W-1:0]  len_ext;
    logic [ROUND_W-1:0] last_idx;
    logic               wd_fire;
    logic               start_ok;

    // Address step and last-round index derived from the latched configuration.
    always_comb begin
        len_ext  = ADDR_W'(issue_length);
        last_idx = num_rounds - ROUND_W'(1);
        start_ok = cfg_start && ((state == S_IDLE) || (state == S_DONE));
    end

`ifdef ROUND_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt;
    logic        timeout_q;

    // Watchdog fires on the TIMEOUT_CYCLES-th cycle spent in ISSUE or DRAIN.
    always_comb begin
        wd_fire = ((state == S_ISSUE) || (state == S_DRAIN)) && (wd_cnt == WD_LAST);
    end

    // Watchdog counter cleared while arming; sticky timeout flag cleared by a new run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == S_ARM) begin
                wd_cnt <= '0;
            end else if (((state == S_ISSUE) || (state == S_DRAIN)) && !wd_fire) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            if (wd_fire) begin
                timeout_q <= 1'b1;
            end else if (start_ok) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign timeout = timeout_q;
`else
    // Without the watchdog a hung issue unit stalls the sequencer.
    always_comb begin
        wd_fire = 1'b0;
    end

    assign timeout = 1'b0;
`endif

    // Round sequencer: state and all registered outputs move together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            num_rounds      <= '0;
            drain_cnt       <= '0;
            issue_rst       <= 1'b1;
            issue_length    <= '0;
            issue_base_addr <= '0;
            round_idx       <= '0;
            round_start     <= 1'b0;
            busy            <= 1'b0;
            all_done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    issue_rst <= 1'b1;
                    if (cfg_start) begin
                        num_rounds      <= cfg_num_rounds;
                        issue_length    <= cfg_filter_length;
                        issue_base_addr <= cfg_base_addr;
                        round_idx       <= '0;
                        if (cfg_num_rounds == '0) begin
                            state       <= S_DONE;
                            all_done    <= 1'b1;
                            busy        <= 1'b0;
                            round_start <= 1'b0;
                        end else begin
                            state       <= S_ARM;
                            all_done    <= 1'b0;
                            busy        <= 1'b1;
                            round_start <= 1'b1;
                        end
                    end
                end

                S_ARM: begin
                    state       <= S_ISSUE;
                    issue_rst   <= 1'b0;
                    round_start <= 1'b0;
                end

                S_ISSUE: begin
                    if (wd_fire) begin
                        state     <= S_DONE;
                        issue_rst <= 1'b1;
                        busy      <= 1'b0;
                        all_done  <= 1'b1;
                    end else if (issue_done) begin
                        state     <= S_DRAIN;
                        issue_rst <= 1'b1;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end

                S_DRAIN: begin
                    if (wd_fire) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        all_done <= 1'b1;
                    end else if (alloc_busy) begin
                        drain_cnt <= DRAIN_LOAD;
                    end else if (drain_cnt == '0) begin
                        state <= S_NEXT;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end

                S_NEXT: begin
                    if (round_idx == last_idx) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        all_done <= 1'b1;
                    end else begin
                        state           <= S_ARM;
                        round_idx       <= round_idx + ROUND_W'(1);
                        issue_base_addr <= issue_base_addr + len_ext;
                        round_start     <= 1'b1;
                    end
                end

                default: begin
                    state       <= S_IDLE;
                    issue_rst   <= 1'b1;
                    round_start <= 1'b0;
                    busy        <= 1'b0;
                    all_done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filter_round_sched.sv
// Directed bench for filter_round_sched with a round scoreboard: expected
// per-round (index, base, length) entries are queued when a run is launched
// and consumed whenever the sequencer pulses round_start.
module tb_filter_round_sched;

    localparam int ROUND_W = 8;
    localparam int LEN_W   = 13;
    localparam int ADDR_W  = 16;
    localparam int DRAIN   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_start = 1'b0;
    logic [ROUND_W-1:0] cfg_num_rounds = '0;
    logic [LEN_W-1:0]   cfg_filter_length = '0;
    logic [ADDR_W-1:0]  cfg_base_addr = '0;
    logic               issue_rst;
    logic [LEN_W-1:0]   issue_length;
    logic [ADDR_W-1:0]  issue_base_addr;
    logic               issue_done = 1'b0;
    logic               alloc_busy = 1'b0;
    logic [ROUND_W-1:0] round_idx;
    logic               round_start;
    logic               busy;
    logic               all_done;
    logic               timeout;

    typedef struct packed {
        logic [ROUND_W-1:0] idx;
        logic [ADDR_W-1:0]  base;
        logic [LEN_W-1:0]   len;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   starts_seen = 0;

    filter_round_sched #(
        .ROUND_W(ROUND_W),
        .LEN_W(LEN_W),
        .ADDR_W(ADDR_W),
        .DRAIN_CYCLES(DRAIN),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_start(cfg_start),
        .cfg_num_rounds(cfg_num_rounds),
        .cfg_filter_length(cfg_filter_length),
        .cfg_base_addr(cfg_base_addr),
        .issue_rst(issue_rst),
        .issue_length(issue_length),
        .issue_base_addr(issue_base_addr),
        .issue_done(issue_done),
        .alloc_busy(alloc_busy),
        .round_idx(round_idx),
        .round_start(round_start),
        .busy(busy),
        .all_done(all_done),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Scoreboard consumer: every round_start must match the next queued round.
    always @(negedge clk) begin
        if (rst === 1'b1 && round_start === 1'b1) begin
            starts_seen++;
            check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                check("round_idx", 32'(round_idx), 32'(cur.idx));
                check("base_addr", 32'(issue_base_addr), 32'(cur.base));
                check("length", 32'(issue_length), 32'(cur.len));
                check("arm_issue_rst", 32'(issue_rst), 32'd1);
                check("arm_busy", 32'(busy), 32'd1);
            end
        end
    end

    task automatic start_run(input int num, input int len, input int base);
        exp_t e;
        for (int r = 0; r < num; r++) begin
            e.idx  = ROUND_W'(r);
            e.base = ADDR_W'(base + r * len);
            e.len  = LEN_W'(len);
            sb.push_back(e);
        end
        cfg_num_rounds    = ROUND_W'(num);
        cfg_filter_length = LEN_W'(len);
        cfg_base_addr     = ADDR_W'(base);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_num_rounds    = ROUND_W'($urandom);
        cfg_filter_length = LEN_W'($urandom);
        cfg_base_addr     = ADDR_W'($urandom);
    endtask

    task automatic wait_issue();
        int n = 0;
        while (issue_rst !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check("issue_released", 32'(issue_rst), 32'd0);
    endtask

    // One round as seen by the issue unit and the allocators.
    task automatic do_round(input int issue_wait, input int busy_cycles, input bit glitch, input bit poke);
        int n = 0;
        wait_issue();
        check("issue_busy", 32'(busy), 32'd1);
        if (poke) begin
            cfg_num_rounds    = 8'd7;
            cfg_base_addr     = 16'h1234;
            cfg_filter_length = 13'd5;
            cfg_start = 1'b1;
            tick();
            cfg_start = 1'b0;
        end
        repeat (issue_wait) tick();
        check("held_in_issue", 32'(issue_rst), 32'd0);
        issue_done = 1'b1;
        tick();
        issue_done = 1'b0;
        check("drain_issue_rst", 32'(issue_rst), 32'd1);
        if (busy_cycles > 0) begin
            alloc_busy = 1'b1;
            repeat (busy_cycles) tick();
            alloc_busy = 1'b0;
        end
        if (glitch) begin
            repeat (2) tick();
            alloc_busy = 1'b1;
            tick();
            alloc_busy = 1'b0;
        end
        do begin
            tick();
            n++;
        end while (round_start !== 1'b1 && all_done !== 1'b1 && n < 40);
        check("drain_gap", 32'(n), 32'd6);
    endtask

    task automatic check_done(input string tag, input int last);
        check({tag, "_all_done"}, 32'(all_done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_issue_rst"}, 32'(issue_rst), 32'd1);
        check({tag, "_idx"}, 32'(round_idx), 32'(last));
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "bench time limit");
    end

    initial begin
        int bad;
        int s0;

        // Asynchronous reset values
        #2 rst = 1'b0;
        #1;
        check("rst_issue_rst", 32'(issue_rst), 32'd1);
        check("rst_round_idx", 32'(round_idx), 32'd0);
        check("rst_base", 32'(issue_base_addr), 32'd0);
        check("rst_length", 32'(issue_length), 32'd0);
        check("rst_round_start", 32'(round_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_all_done", 32'(all_done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        repeat (2) tick();
        rst = 1'b1;

        // Idle hold for 100 cycles with no start
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (issue_rst !== 1'b1 || busy !== 1'b0 || all_done !== 1'b0 || round_start !== 1'b0) bad++;
        end
        check("idle_hold_bad_cycles", 32'(bad), 32'd0);

        // Zero rounds: straight to DONE, issue unit never released
        s0 = starts_seen;
        start_run(0, 9, 16'h0100);
        check("num0_all_done", 32'(all_done), 32'd1);
        check("num0_busy", 32'(busy), 32'd0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (issue_rst !== 1'b1 || all_done !== 1'b1) bad++;
        end
        check("num0_bad_cycles", 32'(bad), 32'd0);
        check("num0_no_start", 32'(starts_seen - s0), 32'd0);

        // Three rounds launched from DONE
        s0 = starts_seen;
        start_run(3, 9, 16'h0100);
        check("restart_clears_done", 32'(all_done), 32'd0);
        do_round(2, 0, 1'b0, 1'b0);
        do_round(5, 0, 1'b0, 1'b0);
        do_round(0, 0, 1'b0, 1'b0);
        check_done("run3", 2);
        check("run3_starts", 32'(starts_seen - s0), 32'd3);

        // Long allocator drain, then a one-cycle glitch restarting the countdown
        start_run(2, 20, 16'h0400);
        do_round(3, 20, 1'b0, 1'b0);
        do_round(1, 0, 1'b1, 1'b0);
        check_done("drain", 1);

        // Address wrap, and a start pulse during ISSUE that must be ignored
        s0 = starts_seen;
        start_run(2, 16, 16'hFFF8);
        do_round(4, 0, 1'b0, 1'b1);
        do_round(0, 0, 1'b0, 1'b0);
        check_done("wrap", 1);
        repeat (10) tick();
        check("wrap_starts", 32'(starts_seen - s0), 32'd2);

        // Zero filter length
        start_run(1, 0, 16'h0200);
        do_round(0, 0, 1'b0, 1'b0);
        check_done("len0", 0);

        // Reset during ISSUE of round 1
        start_run(3, 7, 16'h0040);
        do_round(1, 0, 1'b0, 1'b0);
        wait_issue();
        check("midrun_idx_before", 32'(round_idx), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midrun_issue_rst", 32'(issue_rst), 32'd1);
        check("midrun_round_idx", 32'(round_idx), 32'd0);
        check("midrun_busy", 32'(busy), 32'd0);
        check("midrun_base", 32'(issue_base_addr), 32'd0);
        sb.delete();
        repeat (2) tick();
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (issue_rst !== 1'b1 || busy !== 1'b0 || round_start !== 1'b0) bad++;
        end
        check("post_reset_idle", 32'(bad), 32'd0);

`ifdef ROUND_TIMEOUT_EN
        // Hung issue unit: watchdog ends the run after 50 cycles
        begin
            int n = 0;
            start_run(1, 5, 16'h0000);
            wait_issue();
            do begin
                tick();
                n++;
            end while (all_done !== 1'b1 && n < 200);
            check("wd_cycles", 32'(n), 32'd50);
            check("wd_timeout", 32'(timeout), 32'd1);
            check("wd_round_idx", 32'(round_idx), 32'd0);
            check("wd_issue_rst", 32'(issue_rst), 32'd1);
            start_run(0, 0, 16'h0000);
            check("wd_timeout_cleared", 32'(timeout), 32'd0);
        end
`else
        check("timeout_tied_low", 32'(timeout), 32'd0);
`endif

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
